pipe_exmem_skid: RTL

Parametrised EX-to-MEM pipeline stage for the accelerator core. It replaces the plain stall register with a valid/ready handshaked stage that has a 2-entry skid buffer, so a MEM-side stall never combinationally reaches EX. It also provides a synchronous flush and guaranteed bubble semantics: an invalid slot never writes the register file or memory.

---
 rtl/pipe_exmem_skid_pkg.sv | 37 +++
 rtl/pipe_exmem_skid_buffer.sv | 88 ++++++++
 rtl/pipe_exmem_skid.sv | 94 +++++++++
 3 files changed

// File: rtl/pipe_exmem_skid_pkg.sv
// Shared EX/MEM stage types: control bundle, default-width data bundle and
// the occupancy-derived state encoding used by the generic skid buffer.
package core_pkg;

    // Control bits carried from EX to MEM.
    typedef struct packed {
        logic RegWrite;
        logic ResultSrc;
        logic WDME;
        logic isLoad;
        logic WD3Src;
    } exmem_ctrl_t;

    // Control word of a bubble: nothing is written anywhere.
    localparam exmem_ctrl_t EXMEM_NOP_CTRL = '0;

    // Default core widths. A package typedef cannot take module parameters,
    // so the stage top re-declares this layout with its own WIDTH/RADDR_W.
    localparam int EXMEM_WIDTH   = 32;
    localparam int EXMEM_RADDR_W = 5;

    typedef struct packed {
        logic [EXMEM_WIDTH-1:0]   ALUResult;
        logic [EXMEM_WIDTH-1:0]   WriteData;
        logic [EXMEM_WIDTH-1:0]   PCPlus4;
        logic [EXMEM_RADDR_W-1:0] Rd;
        logic [EXMEM_RADDR_W-1:0] Rs2;
    } exmem_data_t;

    // State is literally {head valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/pipe_exmem_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Head register drives the outputs; skid register catches the one extra
// transfer that can arrive while the consumer stalls.
module skid_buffer
    import core_pkg::*;
#(
    parameter type T       = logic,
    parameter bit  SKID_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  T           in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output T           out_data_o,
    output logic [1:0] occupancy_o
);

    skid_state_t state_q, state_d;
    T            head_q, head_d;
    T            skid_q, skid_d;
    logic        acc, pop;

    // With the skid enabled, in_ready comes straight from a flop, so a MEM
    // stall never reaches EX combinationally; without it, pass-through ready.
    assign in_ready_o  = SKID_EN ? ~state_q[0] : (~state_q[1] | out_ready_i);
    assign out_valid_o = state_q[1];
    assign out_data_o  = head_q;
    assign occupancy_o = {1'b0, state_q[1]} + {1'b0, state_q[0]};

    assign acc = in_valid_i & in_ready_o;
    assign pop = state_q[1] & out_ready_i;

    // State and data registers; reset empties both entries and zeroes data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state: flush wins over everything, otherwise strict FIFO moves.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (acc) begin
                        head_d  = in_data_i;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (acc && pop) begin
                        head_d = in_data_i;
                    end else if (acc) begin
                        // Only reachable with the skid enabled: without it,
                        // in_ready equals pop while the head is occupied.
                        skid_d  = in_data_i;
                        state_d = SKID_FULL;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_exmem_skid.sv
// EX-to-MEM pipeline stage: packs EX fields into one entry, buffers it in a
// skid buffer, and forces bubbles to a no-write control word on the way out.
module pipe_exmem_skid
    import core_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   ALUResultE,
    input  logic [WIDTH-1:0]   WriteDataE,
    input  logic [WIDTH-1:0]   PCPlus4E,
    input  logic [RADDR_W-1:0] RdE,
    input  logic [RADDR_W-1:0] Rs2E,
    input  logic               RegWriteE,
    input  logic               ResultSrcE,
    input  logic               WDMEE,
    input  logic               isLoadE,
    input  logic               WD3SrcE,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUResultM,
    output logic [WIDTH-1:0]   WriteDataM,
    output logic [WIDTH-1:0]   PCPlus4M,
    output logic [RADDR_W-1:0] RdM,
    output logic [RADDR_W-1:0] Rs2M,
    output logic               RegWriteM,
    output logic               ResultSrcM,
    output logic               WDMEM,
    output logic               isLoadM,
    output logic               WD3SrcM,
    output logic [1:0]         occupancy
);

    // Width-matched counterpart of core_pkg::exmem_data_t.
    typedef struct packed {
        logic [WIDTH-1:0]   ALUResult;
        logic [WIDTH-1:0]   WriteData;
        logic [WIDTH-1:0]   PCPlus4;
        logic [RADDR_W-1:0] Rd;
        logic [RADDR_W-1:0] Rs2;
    } stage_data_t;

    typedef struct packed {
        exmem_ctrl_t ctrl;
        stage_data_t data;
    } stage_entry_t;

    stage_entry_t in_entry, head_entry;
    exmem_ctrl_t  ctrl_m;

    assign in_entry.ctrl = '{RegWrite: RegWriteE, ResultSrc: ResultSrcE,
                             WDME: WDMEE, isLoad: isLoadE, WD3Src: WD3SrcE};
    assign in_entry.data = '{ALUResult: ALUResultE, WriteData: WriteDataE,
                             PCPlus4: PCPlus4E, Rd: RdE, Rs2: Rs2E};

    skid_buffer #(
        .T       (stage_entry_t),
        .SKID_EN (SKID_EN)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head_entry),
        .occupancy_o (occupancy)
    );

    // A bubble must never write the register file or memory, and must not
    // present register addresses that forwarding logic could match.
    assign ctrl_m     = out_valid ? head_entry.ctrl : EXMEM_NOP_CTRL;
    assign RegWriteM  = ctrl_m.RegWrite;
    assign ResultSrcM = ctrl_m.ResultSrc;
    assign WDMEM      = ctrl_m.WDME;
    assign isLoadM    = ctrl_m.isLoad;
    assign WD3SrcM    = ctrl_m.WD3Src;
    assign RdM        = out_valid ? head_entry.data.Rd  : '0;
    assign Rs2M       = out_valid ? head_entry.data.Rs2 : '0;

    // Data buses hold their last value across bubbles.
    assign ALUResultM = head_entry.data.ALUResult;
    assign WriteDataM = head_entry.data.WriteData;
    assign PCPlus4M   = head_entry.data.PCPlus4;

endmodule
